// File: rtl/sum_result_fifo.sv
// ============================================================================
// Module   : sum_result_fifo
// Brief    : FIFO for {carry, sum} adder results, sticky drop flag. Optional
//            running total enabled by macro SUM_RESULT_FIFO_ACCUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_result_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [7:0]               Sum_result,
   input  logic                     Sum_carry,
   input  logic                     Data_ready,
   output logic [8:0]               Out_data,
   output logic                     Out_valid,
   input  logic                     Out_ready,
   output logic [$clog2(DEPTH):0]   Fifo_count,
   output logic                     Overflow
`ifdef SUM_RESULT_FIFO_ACCUM_EN
   ,
   output logic [15:0]              Accum
`endif
);

   localparam int                 c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]      c_FULL = DEPTH[c_AW:0];

   logic [8:0]      r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;
   logic            r_valid;
   logic            r_overflow;

   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic [8:0]      w_entry;
   logic [c_AW:0]   w_count_next;

   assign w_full  = (r_count == c_FULL);
   assign w_pop   = r_valid & Out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push  = Data_ready & (~w_full | w_pop);
   assign w_entry = {Sum_carry, Sum_result};

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_valid <= (w_count_next != '0);
         if (Data_ready && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // Storage needs no reset: an empty FIFO masks its contents on Out_data.
   always_ff @(posedge clk) begin
      if (reset_n && w_push) r_mem[r_wr_ptr] <= w_entry;
   end

   assign Out_data   = r_valid ? r_mem[r_rd_ptr] : 9'h000;
   assign Out_valid  = r_valid;
   assign Fifo_count = r_count;
   assign Overflow   = r_overflow;

`ifdef SUM_RESULT_FIFO_ACCUM_EN
   logic [15:0] r_accum;

   always_ff @(posedge clk) begin
      if (!reset_n)    r_accum <= '0;
      else if (w_push) r_accum <= r_accum + {7'd0, w_entry};
   end

   assign Accum = r_accum;
`endif

endmodule

`default_nettype wire
